// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes and
// the datapath select values the controller drives.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_LOAD  = 4'b0101;
  localparam logic [3:0] OP_STORE = 4'b0110;
  localparam logic [3:0] OP_BEQ   = 4'b0111;
  localparam logic [3:0] OP_JMP   = 4'b1000;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic is_legal(input logic [3:0] op);
    return (op <= OP_JMP) || (op == OP_HALT);
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive memory-wait cycles; o_timeout flags the cycle in which the
// MEM_TIMEOUT-th consecutive not-ready cycle occurs. MEM_TIMEOUT = 0 disables it.
module mem_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 2);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_srst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  // r_count holds prior wait cycles, so the current one is the (r_count+1)-th.
  assign o_timeout = (MEM_TIMEOUT != 0) && i_en && (r_count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Moore-style multicycle control FSM for the 8-bit teaching CPU.
// Optional build macro INSTR_COUNT_EN adds the retired-instruction counter port.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int ICNT_W      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [2:0] state_o,
  output logic       illegal,
  output logic       halted,
  output logic       fault
`ifdef INSTR_COUNT_EN
  ,
  output logic [ICNT_W-1:0] instr_count
`endif
);

  state_t r_state;
  state_t w_next;
  logic   w_timeout;
  logic   w_wd_en;
  logic   w_wd_clr;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_wd_en  = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;
  assign w_wd_clr = mem_ready || (w_next != r_state);

  mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .i_clk    (clock),
    .i_srst   (reset),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_timeout(w_timeout)
  );

  always_comb begin
    w_next     = r_state;
    pc_write   = 1'b0;
    pc_src     = PC_INC;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;

    case (r_state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = ST_DECODE;
        end else if (w_timeout) begin
          w_next = ST_ERR;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_JMP) begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
          w_next   = ST_FETCH;
        end else if (opcode == OP_HALT) begin
          w_next = ST_HALT;
        end else if (!is_legal(opcode)) begin
          illegal = 1'b1;
          w_next  = ST_FETCH;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_next = ST_FETCH;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            alu_op = rtype_alu(opcode);
            w_next = ST_WB;
          end
          OP_ADDI: begin
            alu_src_b = SRCB_IMM;
            w_next    = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b = SRCB_IMM;
            w_next    = ST_MEM;
          end
          OP_BEQ: begin
            alu_op = ALU_SUB;
            if (zero) begin
              pc_write = 1'b1;
              pc_src   = PC_BRANCH;
            end
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_read  = (opcode == OP_LOAD);
        mem_write = (opcode != OP_LOAD);
        if (mem_ready) begin
          w_next = (opcode == OP_LOAD) ? ST_WB : ST_FETCH;
        end else if (w_timeout) begin
          w_next = ST_ERR;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_ADDI) || (opcode == OP_LOAD);
        mem_to_reg = (opcode == OP_LOAD);
        w_next     = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      ST_ERR:  fault  = 1'b1;
      default: w_next = ST_FETCH;
    endcase

    // A transaction cut short by reset must not commit anything this cycle.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state_o = r_state;

`ifdef INSTR_COUNT_EN
  logic [ICNT_W-1:0] r_icnt;
  logic              w_retire;

  assign w_retire = (w_next == ST_FETCH) &&
                    (((r_state == ST_DECODE) && (opcode == OP_JMP)) ||
                     (r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_icnt <= '0;
    end else if (w_retire) begin
      r_icnt <= r_icnt + ICNT_W'(1);
    end
  end

  assign instr_count = r_icnt;
`else
  logic [ICNT_W-1:0] w_unused_icnt;
  assign w_unused_icnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is modelled as a list
// of phases with durations, from which state trace and strobe totals are predicted.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [2:0] state_o;
  logic       illegal;
  logic       halted;
  logic       fault;
`ifdef INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  int n_checks  = 0;
  int n_errors  = 0;
  int n_retired = 0;

  always #5 clk = ~clk;

  multicycle_control #(
    .MEM_TIMEOUT(16),
    .ICNT_W     (16)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .ir_write  (ir_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .mem_to_reg(mem_to_reg),
    .state_o   (state_o),
    .illegal   (illegal),
    .halted    (halted),
    .fault     (fault)
`ifdef INSTR_COUNT_EN
    ,
    .instr_count(instr_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Runs one instruction starting in FETCH; wf/wm are not-ready cycles before
  // the fetch and memory accesses complete.
  task automatic run_instr(input logic [3:0] op, input logic zf, input int wf, input int wm);
    logic [2:0] exp_st[$];
    bit is_r, legal, is_mem, wr, ex;
    int mem_end;
    int c_pcw = 0, c_irw = 0, c_rw = 0, c_mr = 0, c_mw = 0, c_ill = 0, c_bad = 0;
    logic [1:0] last_src = 2'd0;
    logic       got_dst = 1'b0, got_m2r = 1'b0;
    logic [2:0] got_alu = 3'd0;
    logic [1:0] got_srcb = 2'd0;
    logic [2:0] exp_alu;

    is_r   = (op <= 4'd3);
    legal  = (op <= 4'd8);
    is_mem = (op == 4'd5) || (op == 4'd6);
    wr     = is_r || (op == 4'd4) || (op == 4'd5);
    ex     = legal && (op != 4'd8);
    repeat (wf + 1) exp_st.push_back(3'd0);
    exp_st.push_back(3'd1);
    if (ex) exp_st.push_back(3'd2);
    if (is_mem) repeat (wm + 1) exp_st.push_back(3'd3);
    if (wr) exp_st.push_back(3'd4);
    mem_end = wf + 3 + wm;

    opcode = op;
    zero   = zf;
    for (int k = 0; k < exp_st.size(); k++) begin
      if (exp_st[k] == 3'd0)      mem_ready = (k == wf);
      else if (exp_st[k] == 3'd3) mem_ready = (k == mem_end);
      else                        mem_ready = 1'($urandom_range(0, 1));
      #2;
      check($sformatf("state op%0d cyc%0d", op, k), state_o, exp_st[k]);
      c_pcw += pc_write;
      c_irw += ir_write;
      c_rw  += reg_write;
      c_mr  += mem_read;
      c_mw  += mem_write;
      c_ill += illegal;
      if ((mem_read && mem_write) || (reg_write && pc_write)) c_bad++;
      if (pc_write && exp_st[k] != 3'd0) last_src = pc_src;
      if (reg_write) begin
        got_dst = reg_dst;
        got_m2r = mem_to_reg;
      end
      if (ex && k == wf + 2) begin
        got_alu  = alu_op;
        got_srcb = alu_src_b;
      end
      tick();
    end

    check("ir_write cnt", c_irw, 1);
    check("pc_write cnt", c_pcw, 1 + int'(op == 4'd8) + int'(op == 4'd7 && zf));
    check("pc_src", last_src, (op == 4'd8) ? 2 : ((op == 4'd7 && zf) ? 1 : 0));
    check("reg_write cnt", c_rw, wr ? 1 : 0);
    check("mem_read cnt", c_mr, (wf + 1) + ((op == 4'd5) ? wm + 1 : 0));
    check("mem_write cnt", c_mw, (op == 4'd6) ? wm + 1 : 0);
    check("illegal cnt", c_ill, legal ? 0 : 1);
    check("invariants", c_bad, 0);
    if (wr) begin
      check("reg_dst", got_dst, is_r ? 0 : 1);
      check("mem_to_reg", got_m2r, (op == 4'd5) ? 1 : 0);
    end
    if (ex) begin
      exp_alu = (op == 4'd7) ? 3'd1 : (is_r ? op[2:0] : 3'd0);
      check("alu_op exec", got_alu, exp_alu);
      check("alu_src_b exec", got_srcb, (is_r || op == 4'd7) ? 0 : 2);
    end
    if (legal) n_retired++;
  endtask

  // Holds memory not-ready for 16 cycles in FETCH or in a STORE's MEM phase.
  task automatic wd_test(input bit in_mem);
    opcode = 4'd6;
    zero   = 1'b0;
    if (in_mem) begin
      mem_ready = 1'b1;
      tick();
      tick();
      tick();
    end
    for (int k = 0; k < 16; k++) begin
      mem_ready = 1'b0;
      #2;
      check($sformatf("wd wait cyc%0d", k), state_o, in_mem ? 3 : 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("wd state err", state_o, 3'd6);
    check("wd fault", fault, 1'b1);
    check("wd strobes", {mem_read, mem_write, pc_write, ir_write}, 4'b0);
    tick();
    check("wd err sticky", state_o, 3'd6);
    pulse_reset();
    mem_ready = 1'b0;
    #1;
    check("wd reset state", state_o, 3'd0);
    check("wd reset fault", fault, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] op;
    reset     = 1'b1;
    opcode    = 4'd0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    tick();
    #1;
    check("rst strobes", {pc_write, ir_write, reg_write, mem_write}, 4'b0);
    reset     = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("rst state", state_o, 3'd0);
    check("rst mem_read", mem_read, 1'b1);
    check("rst alu_src_b", alu_src_b, 2'b01);
    check("rst alu_op", alu_op, 3'b000);
    check("rst pc_write", pc_write, 1'b0);
    check("rst flags", {halted, fault, illegal, reg_write, mem_write}, 5'b0);
`ifdef INSTR_COUNT_EN
    check("rst instr_count", instr_count, 0);
`endif
    tick();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(9, 14));
      else                           op = 4'($urandom_range(0, 8));
      run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end
`ifdef INSTR_COUNT_EN
    check("instr_count random", instr_count, n_retired);
`endif

    run_instr(4'd0, 1'b0, 0, 0);
    run_instr(4'd5, 1'b0, 0, 3);
    run_instr(4'd7, 1'b1, 0, 0);
    run_instr(4'd7, 1'b0, 0, 0);
    run_instr(4'd10, 1'b0, 0, 0);
    run_instr(4'd5, 1'b0, 15, 15);
    run_instr(4'd6, 1'b0, 15, 15);

    opcode    = 4'd15;
    mem_ready = 1'b1;
    tick();
    #1;
    check("halt decode", state_o, 3'd1);
    tick();
    for (int k = 0; k < 20; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #2;
      check("halt state", state_o, 3'd5);
      check("halted", halted, 1'b1);
      check("halt strobes", {pc_write, ir_write, reg_write, mem_read, mem_write}, 5'b0);
      tick();
    end
    pulse_reset();

    wd_test(1'b0);
    wd_test(1'b1);

    opcode    = 4'd6;
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    check("store mem_write", mem_write, 1'b1);
    reset = 1'b1;
    #1;
    check("store rst mem_write", mem_write, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check("store abort state", state_o, 3'd0);
    check("store abort mem_write", mem_write, 1'b0);
    tick();
    pulse_reset();
`ifdef INSTR_COUNT_EN
    #1;
    check("icnt after reset", instr_count, 0);
`endif
    for (int i = 0; i < 5; i++) run_instr(4'd0, 1'b0, 0, 0);
`ifdef INSTR_COUNT_EN
    check("icnt five adds", instr_count, 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style multicycle control FSM for the 8-bit teaching CPU.
- Sequences fetch, decode, execute, memory and write-back over the shared ALU, memory port and the 8x8 register bank (3-bit addresses, r0 hardwired zero).
- Drives the register bank's write strobe, PC/IR enables and datapath muxes.
- Waits on a memory ready handshake; a watchdog flags a stuck memory.

Parameters:
- MEM_TIMEOUT, 16: consecutive not-ready cycles in a memory wait state before fault; 0 disables the watchdog.
- ICNT_W, 16: width of the retired-instruction counter (optional feature only).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  4  IR[15:12], stable from DECODE until next FETCH
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory has completed the current read/write
- pc_write  out  1  PC load enable
- pc_src  out  2  PC source: 00 = PC+1, 01 = branch target, 10 = jump target
- ir_write  out  1  IR load enable
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- alu_src_b  out  2  ALU B operand: 00 = reg, 01 = const 1, 10 = sign-extended imm
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR
- reg_write  out  1  register bank write strobe
- reg_dst  out  1  destination: 0 = rd, 1 = rt
- mem_to_reg  out  1  write-back source: 0 = ALU, 1 = memory
- state_o  out  3  current state encoding
- illegal  out  1  one-cycle pulse on an undefined opcode
- halted  out  1  high in HALT
- fault  out  1  high in ERR

Behaviour:
- Reset, checked at the clock edge:
  - state = FETCH and watchdog counter = 0.
  - All outputs 0 except the FETCH decode below, which therefore appears in the first cycle after reset.
  - Reset mid-transaction aborts it immediately. No write strobe is asserted in the reset cycle.
- Opcodes: ADD 0000, SUB 0001, AND 0010, OR 0011, ADDI 0100, LOAD 0101, STORE 0110, BEQ 0111, JMP 1000, HALT 1111. All other opcodes are illegal.
- FETCH (000):
  - Outputs: mem_read = 1, alu_src_b = 01, alu_op = ADD, pc_src = 00.
  - When mem_ready = 1: ir_write = 1 and pc_write = 1 in the same cycle, then go to DECODE. Otherwise stay.
- DECODE (001):
  - JMP: pc_write = 1, pc_src = 10, then FETCH.
  - HALT: go to HALT.
  - Illegal opcode: illegal = 1, then FETCH.
  - Any other opcode: go to EXEC.
- EXEC (010):
  - R-type (ADD, SUB, AND, OR): alu_src_b = 00, alu_op = opcode[2:0], then WB.
  - ADDI, LOAD, STORE: alu_src_b = 10, alu_op = ADD. ADDI goes to WB; LOAD and STORE go to MEM.
  - BEQ: alu_src_b = 00, alu_op = SUB. If zero = 1: pc_write = 1, pc_src = 01. Then FETCH.
- MEM (011):
  - LOAD holds mem_read = 1; STORE holds mem_write = 1, until mem_ready = 1.
  - Then LOAD goes to WB and STORE goes to FETCH.
- WB (100):
  - reg_write = 1 for exactly one cycle, then FETCH.
  - reg_dst = 0 for R-type, 1 for ADDI and LOAD.
  - mem_to_reg = 1 only for LOAD.
- HALT (101): halted = 1, all strobes 0; left only by reset.
- ERR (110): fault = 1, all strobes 0; left only by reset.
- Watchdog:
  - Counts consecutive cycles in FETCH or MEM with mem_ready = 0. Cleared on any state change or when mem_ready = 1.
  - When the count reaches MEM_TIMEOUT, the next state is ERR.
  - If mem_ready = 1 in that same cycle, ready wins.
- Invariants:
  - mem_read and mem_write are never both high.
  - reg_write and pc_write are never high in the same cycle, except for FETCH's pc_write with ir_write.
  - Instruction latencies with zero-wait memory:
    - R-type / ADDI: 4 cycles.
    - LOAD: 5 cycles.
    - STORE: 4 cycles.
    - BEQ: 3 cycles.
    - JMP: 2 cycles.

Optional Feature:
- Macro INSTR_COUNT_EN.
- Defined:
  - Adds output instr_count (ICNT_W bits), reset to 0.
  - Increments by 1 on every transition into FETCH from DECODE (JMP only), EXEC, MEM or WB.
  - Not incremented on illegal-opcode returns.
  - Wraps modulo 2^ICNT_W.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum (FETCH..ERR, 3-bit);
  - opcode constants;
  - alu_op, alu_src_b and pc_src encodings.
- One sub-module, mem_watchdog: counter with clear/enable inputs and a timeout output, parameterised by MEM_TIMEOUT.

Test Plan:
- ADD with mem_ready tied to 1 → state sequence 000, 001, 010, 100, 000; reg_write high only in cycle 4, with reg_dst = 0 and alu_op = 000.
- LOAD with mem_ready low for 3 cycles in MEM → mem_read held 3+1 cycles; WB has mem_to_reg = 1 and reg_dst = 1.
- BEQ with zero = 1, then with zero = 0 → pc_write with pc_src = 01 in EXEC only in the first case; both return to FETCH after 3 cycles.
- Opcode 1010 → illegal pulses for 1 cycle in DECODE, no strobes, back to FETCH. Then HALT → halted = 1, held for 20 cycles.
- mem_ready held 0 in FETCH with MEM_TIMEOUT = 16 → ERR entered after 16 wait cycles, fault = 1. Pulse reset → FETCH, fault = 0.
- Reset asserted during MEM of a STORE → next cycle FETCH with mem_write = 0. With INSTR_COUNT_EN, instr_count = 0 after reset and equals 5 after 5 retired ADDs.
